// File: rtl/ant_move_arbiter.sv
// Round-robin arbiter that shares the world-update port among the ant controllers.
// Escape-flagged commands win. Each grant runs through issue, completion wait and settle.
module ant_move_arbiter #(
  parameter int N_ANT    = 4,
  parameter int ID_W     = 2,
  parameter int PH_WIDTH = 2,
  parameter int SETTLE   = 3,
  parameter int TIMEOUT  = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_ANT-1:0]          req_valid,
  input  logic [2*N_ANT-1:0]        req_move,
  input  logic [PH_WIDTH*N_ANT-1:0] req_ph,
  input  logic [N_ANT-1:0]          req_esc,
  output logic [N_ANT-1:0]          req_ready,
  output logic                      w_valid,
  output logic [ID_W-1:0]           w_ant_id,
  output logic [1:0]                w_move,
  output logic [PH_WIDTH-1:0]       w_ph,
  input  logic                      w_ready,
  input  logic                      w_done,
  output logic                      busy,
  output logic                      err
);

  localparam logic [1:0] MOVE_HALT = 2'b00;
  localparam int WCNT_W      = $clog2(TIMEOUT + 1);
  localparam int SCNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_SETTLE} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [N_ANT-1:0]      r_slotFull;
  logic [N_ANT-1:0]      r_slotEsc;
  logic [1:0]            r_slotMove [N_ANT];
  logic [PH_WIDTH-1:0]   r_slotPh   [N_ANT];
  logic [ID_W-1:0]       r_rrPtr;
  logic [ID_W-1:0]       r_antId;
  logic [1:0]            r_move;
  logic [PH_WIDTH-1:0]   r_ph;
  logic                  r_err;
  logic [WCNT_W-1:0]     r_waitCnt;
  logic [SCNT_W-1:0]     r_settleCnt;
  logic [N_ANT-1:0]      w_elig;
  logic [N_ANT-1:0]      w_escElig;
  logic [N_ANT-1:0]      w_pool;
  logic                  w_anyCand;
  logic [ID_W-1:0]       w_grantId;
  logic                  w_handshake;
  logic                  w_timeout;

  assign req_ready   = ~r_slotFull;
  assign w_ant_id    = r_antId;
  assign w_move      = r_move;
  assign w_ph        = r_ph;
  assign err         = r_err;
  assign w_handshake = (r_state == ST_ISSUE) && w_ready;
  // The timeout cycle is the TIMEOUT-th cycle spent waiting; a w_done in that cycle still wins.
  assign w_timeout   = (r_state == ST_WAIT) && (r_waitCnt == WCNT_W'(TIMEOUT - 1));

  // HALT slots are never candidates; any escape candidate masks out the others.
  always_comb begin
    for (int i = 0; i < N_ANT; i++) begin
      w_elig[i] = r_slotFull[i] && (r_slotMove[i] != MOVE_HALT);
    end
    w_escElig = w_elig & r_slotEsc;
    w_pool    = (|w_escElig) ? w_escElig : w_elig;
    w_anyCand = |w_pool;
  end

  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    w_grantId = '0;
    for (int k = 0; k < N_ANT; k++) begin
      idx = (int'(r_rrPtr) + k) % N_ANT;
      if (!found && w_pool[idx]) begin
        found     = 1'b1;
        w_grantId = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slotFull <= '0;
      r_slotEsc  <= '0;
      for (int i = 0; i < N_ANT; i++) begin
        r_slotMove[i] <= '0;
        r_slotPh[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_ANT; i++) begin
        if (req_valid[i] && !r_slotFull[i]) begin
          r_slotFull[i] <= 1'b1;
          r_slotEsc[i]  <= req_esc[i];
          r_slotMove[i] <= req_move[2*i +: 2];
          r_slotPh[i]   <= req_ph[PH_WIDTH*i +: PH_WIDTH];
        end else if (r_slotFull[i] && ((r_slotMove[i] == MOVE_HALT) ||
                     (w_handshake && (r_antId == ID_W'(i))))) begin
          r_slotFull[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:   if (w_anyCand) w_nextState = ST_ISSUE;
      ST_ISSUE:  if (w_ready) w_nextState = ST_WAIT;
      ST_WAIT:   if (w_done || w_timeout) w_nextState = (SETTLE == 0) ? ST_IDLE : ST_SETTLE;
      ST_SETTLE: if (r_settleCnt == SCNT_W'(SETTLE_LAST)) w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    w_valid = (r_state == ST_ISSUE);
    busy    = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt   <= '0;
      r_settleCnt <= '0;
    end else begin
      r_waitCnt   <= (r_state == ST_WAIT)   ? r_waitCnt + 1'b1   : '0;
      r_settleCnt <= (r_state == ST_SETTLE) ? r_settleCnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_antId <= '0;
      r_move  <= '0;
      r_ph    <= '0;
      r_rrPtr <= '0;
      r_err   <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && w_anyCand) begin
        r_antId <= w_grantId;
        r_move  <= r_slotMove[w_grantId];
        r_ph    <= r_slotPh[w_grantId];
        r_rrPtr <= (w_grantId == ID_W'(N_ANT - 1)) ? '0 : w_grantId + 1'b1;
      end
      if (w_timeout && !w_done) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ant_move_arbiter.sv
// Scenario bench for ant_move_arbiter: expected grants go into a queue as requests are posted,
// and a small world model records every w handshake and replays w_done pulses.
`timescale 1ns/1ps
module tb_ant_move_arbiter;

  localparam int N_ANT    = 4;
  localparam int ID_W     = 2;
  localparam int PH_WIDTH = 2;
  localparam int SETTLE   = 3;
  localparam int TIMEOUT  = 15;
  localparam logic [1:0] HALT = 2'b00, RIGHT = 2'b01, LEFT = 2'b10, FORWARD = 2'b11;

  typedef logic [ID_W+2+PH_WIDTH-1:0] txn_t;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [N_ANT-1:0]          req_valid = '0;
  logic [2*N_ANT-1:0]        req_move = '0;
  logic [PH_WIDTH*N_ANT-1:0] req_ph = '0;
  logic [N_ANT-1:0]          req_esc = '0;
  logic [N_ANT-1:0]          req_ready;
  logic                      w_valid;
  logic [ID_W-1:0]           w_ant_id;
  logic [1:0]                w_move;
  logic [PH_WIDTH-1:0]       w_ph;
  logic                      w_ready = 1'b1;
  logic                      w_done = 1'b0;
  logic                      busy;
  logic                      err;

  int   nChecks = 0;
  int   nFails = 0;
  int   doneDelay = -1;
  int   doneCountdown = 0;
  logic hsSeen;
  txn_t expQ[$];
  txn_t obsQ[$];

  ant_move_arbiter #(
    .N_ANT(N_ANT), .ID_W(ID_W), .PH_WIDTH(PH_WIDTH), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_move(req_move), .req_ph(req_ph),
    .req_esc(req_esc), .req_ready(req_ready), .w_valid(w_valid), .w_ant_id(w_ant_id),
    .w_move(w_move), .w_ph(w_ph), .w_ready(w_ready), .w_done(w_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // World model: logs each handshake and pulses w_done doneDelay cycles after it (never if <= 0).
  always @(posedge clk) begin
    hsSeen = rst_n && w_valid && w_ready;
    if (hsSeen) obsQ.push_back({w_ant_id, w_move, w_ph});
    #1;
    w_done = 1'b0;
    if (!rst_n) doneCountdown = 0;
    else if (hsSeen && doneDelay > 0) doneCountdown = doneDelay;
    if (doneCountdown > 0) begin
      doneCountdown--;
      if (doneCountdown == 0) w_done = 1'b1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic loadReq(input int ant, input logic [1:0] mv, input logic [PH_WIDTH-1:0] ph,
                         input logic esc);
    req_valid[ant] = 1'b1;
    req_move[2*ant +: 2] = mv;
    req_ph[PH_WIDTH*ant +: PH_WIDTH] = ph;
    req_esc[ant] = esc;
  endtask

  // Holds the loaded requests for one clock edge, then withdraws them.
  task automatic applyStimulus();
    tick(1);
    req_valid = '0;
    req_esc = '0;
  endtask

  task automatic waitObs(input int n, input int budget, output bit ok);
    int c = 0;
    while (obsQ.size() < n && c < budget) begin
      tick(1);
      c++;
    end
    ok = (obsQ.size() >= n);
  endtask

  task automatic waitIdle(input int budget, output bit ok);
    int c = 0;
    while (busy !== 1'b0 && c < budget) begin
      tick(1);
      c++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    req_valid = '0;
    req_esc = '0;
    w_ready = 1'b1;
    doneDelay = -1;
    tick(2);
    expQ.delete();
    obsQ.delete();
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    nChecks++;
    if (req_ready !== 4'hF) begin nFails++; $display("[TB] FAIL reset_req_ready: got %h, expected f", req_ready); end
    nChecks++;
    if ({w_valid, w_ant_id, w_move, w_ph} !== 7'd0) begin
      nFails++; $display("[TB] FAIL reset_w_bus: got %b, expected 0000000", {w_valid, w_ant_id, w_move, w_ph});
    end
    nChecks++;
    if ({busy, err} !== 2'b00) begin nFails++; $display("[TB] FAIL reset_busy_err: got %b, expected 00", {busy, err}); end
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic test_single();
    resetDut();
    doneDelay = 3;
    loadReq(2, FORWARD, 2'd1, 1'b0);
    expQ.push_back({2'd2, FORWARD, 2'd1});
    applyStimulus();
    nChecks++;
    if ({req_ready[2], w_valid} !== 2'b00) begin
      nFails++; $display("[TB] FAIL single_t1: got %b, expected 00", {req_ready[2], w_valid});
    end
    tick(1);
    nChecks++;
    if ({w_valid, w_ant_id, w_move, w_ph, busy} !== {1'b1, 2'd2, FORWARD, 2'd1, 1'b1}) begin
      nFails++; $display("[TB] FAIL single_issue: got %b, expected 11011011", {w_valid, w_ant_id, w_move, w_ph, busy});
    end
    tick(1);
    nChecks++;
    if ({w_valid, req_ready[2]} !== 2'b01) begin
      nFails++; $display("[TB] FAIL single_reopen: got %b, expected 01", {w_valid, req_ready[2]});
    end
    tick(5);
    nChecks++;
    if (busy !== 1'b1) begin nFails++; $display("[TB] FAIL single_busy_settle: got %b, expected 1", busy); end
    tick(1);
    nChecks++;
    if ({busy, err} !== 2'b00) begin nFails++; $display("[TB] FAIL single_idle: got %b, expected 00", {busy, err}); end
    while (expQ.size() > 0) begin
      txn_t e, o;
      e = expQ.pop_front();
      o = 'x;
      if (obsQ.size() > 0) o = obsQ.pop_front();
      nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL single_txn: got %h, expected %h", o, e); end
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    int c = 0;
    resetDut();
    doneDelay = 1;
    loadReq(0, FORWARD, 2'd0, 1'b0);
    loadReq(1, RIGHT, 2'd1, 1'b0);
    loadReq(2, LEFT, 2'd2, 1'b0);
    loadReq(3, FORWARD, 2'd3, 1'b0);
    expQ.push_back({2'd0, FORWARD, 2'd0});
    expQ.push_back({2'd1, RIGHT, 2'd1});
    expQ.push_back({2'd2, LEFT, 2'd2});
    expQ.push_back({2'd3, FORWARD, 2'd3});
    applyStimulus();
    while (req_ready[0] !== 1'b1 && c < 100) begin
      tick(1);
      c++;
    end
    nChecks++;
    if (req_ready[0] !== 1'b1) begin nFails++; $display("[TB] FAIL rr_reopen_timeout: got %b, expected 1", req_ready[0]); end
    loadReq(0, RIGHT, 2'd2, 1'b0);
    expQ.push_back({2'd0, RIGHT, 2'd2});
    applyStimulus();
    waitObs(5, 200, ok);
    nChecks++;
    if (!ok) begin nFails++; $display("[TB] FAIL rr_wait: got %0d grants, expected 5", obsQ.size()); end
    tick(20);
    while (expQ.size() > 0) begin
      txn_t e, o;
      e = expQ.pop_front();
      o = 'x;
      if (obsQ.size() > 0) o = obsQ.pop_front();
      nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL rr_grant: got %h, expected %h", o, e); end
    end
    nChecks++;
    if (obsQ.size() != 0) begin nFails++; $display("[TB] FAIL rr_extra: got %0d extra grants, expected 0", obsQ.size()); end
  endtask

  task automatic test_escape();
    bit ok;
    resetDut();
    doneDelay = 1;
    loadReq(1, LEFT, 2'd1, 1'b0);
    loadReq(3, RIGHT, 2'd2, 1'b1);
    expQ.push_back({2'd3, RIGHT, 2'd2});
    expQ.push_back({2'd1, LEFT, 2'd1});
    applyStimulus();
    waitObs(2, 100, ok);
    nChecks++;
    if (!ok) begin nFails++; $display("[TB] FAIL esc_wait: got %0d grants, expected 2", obsQ.size()); end
    tick(8);
    while (expQ.size() > 0) begin
      txn_t e, o;
      e = expQ.pop_front();
      o = 'x;
      if (obsQ.size() > 0) o = obsQ.pop_front();
      nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL esc_grant: got %h, expected %h", o, e); end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    resetDut();
    w_ready = 1'b0;
    doneDelay = 2;
    loadReq(1, LEFT, 2'd3, 1'b0);
    expQ.push_back({2'd1, LEFT, 2'd3});
    applyStimulus();
    tick(1);
    for (int i = 0; i < 10; i++) begin
      nChecks++;
      if ({w_valid, w_ant_id, w_move, w_ph, req_ready[1], err} !== {1'b1, 2'd1, LEFT, 2'd3, 1'b0, 1'b0}) begin
        nFails++;
        $display("[TB] FAIL bp_hold: cycle %0d got %b, expected 101101100", i,
                 {w_valid, w_ant_id, w_move, w_ph, req_ready[1], err});
      end
      tick(1);
    end
    w_ready = 1'b1;
    tick(1);
    nChecks++;
    if ({w_valid, req_ready[1]} !== 2'b01) begin
      nFails++; $display("[TB] FAIL bp_release: got %b, expected 01", {w_valid, req_ready[1]});
    end
    waitIdle(50, ok);
    nChecks++;
    if ({ok, err} !== 2'b10) begin nFails++; $display("[TB] FAIL bp_done: got %b, expected 10", {ok, err}); end
    while (expQ.size() > 0) begin
      txn_t e, o;
      e = expQ.pop_front();
      o = 'x;
      if (obsQ.size() > 0) o = obsQ.pop_front();
      nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL bp_txn: got %h, expected %h", o, e); end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    resetDut();
    loadReq(0, FORWARD, 2'd1, 1'b0);
    loadReq(2, RIGHT, 2'd2, 1'b0);
    expQ.push_back({2'd0, FORWARD, 2'd1});
    expQ.push_back({2'd2, RIGHT, 2'd2});
    applyStimulus();
    tick(1);
    tick(TIMEOUT);
    nChecks++;
    if ({err, busy} !== 2'b01) begin nFails++; $display("[TB] FAIL to_before: got %b, expected 01", {err, busy}); end
    doneDelay = 2;
    tick(1);
    nChecks++;
    if ({err, busy} !== 2'b11) begin nFails++; $display("[TB] FAIL to_fire: got %b, expected 11", {err, busy}); end
    waitObs(2, 100, ok);
    nChecks++;
    if (!ok) begin nFails++; $display("[TB] FAIL to_next_grant: got %0d grants, expected 2", obsQ.size()); end
    waitIdle(50, ok);
    nChecks++;
    if ({ok, err} !== 2'b11) begin nFails++; $display("[TB] FAIL to_sticky: got %b, expected 11", {ok, err}); end
    while (expQ.size() > 0) begin
      txn_t e, o;
      e = expQ.pop_front();
      o = 'x;
      if (obsQ.size() > 0) o = obsQ.pop_front();
      nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL to_txn: got %h, expected %h", o, e); end
    end
  endtask

  task automatic test_timeout_edge();
    bit ok;
    resetDut();
    doneDelay = TIMEOUT;
    loadReq(3, FORWARD, 2'd0, 1'b0);
    expQ.push_back({2'd3, FORWARD, 2'd0});
    applyStimulus();
    tick(1);
    tick(TIMEOUT + 1);
    nChecks++;
    if ({err, busy} !== 2'b01) begin nFails++; $display("[TB] FAIL toedge_settle: got %b, expected 01", {err, busy}); end
    waitIdle(50, ok);
    nChecks++;
    if ({ok, err} !== 2'b10) begin nFails++; $display("[TB] FAIL toedge_idle: got %b, expected 10", {ok, err}); end
    while (expQ.size() > 0) begin
      txn_t e, o;
      e = expQ.pop_front();
      o = 'x;
      if (obsQ.size() > 0) o = obsQ.pop_front();
      nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL toedge_txn: got %h, expected %h", o, e); end
    end
  endtask

  task automatic test_halt();
    resetDut();
    loadReq(1, HALT, 2'd1, 1'b0);
    applyStimulus();
    nChecks++;
    if ({req_ready[1], w_valid, busy} !== 3'b000) begin
      nFails++; $display("[TB] FAIL halt_load: got %b, expected 000", {req_ready[1], w_valid, busy});
    end
    tick(1);
    nChecks++;
    if (req_ready[1] !== 1'b1) begin nFails++; $display("[TB] FAIL halt_release: got %b, expected 1", req_ready[1]); end
    for (int i = 0; i < 4; i++) begin
      nChecks++;
      if ({w_valid, busy} !== 2'b00) begin
        nFails++; $display("[TB] FAIL halt_quiet: cycle %0d got %b, expected 00", i, {w_valid, busy});
      end
      tick(1);
    end
    nChecks++;
    if (obsQ.size() != 0) begin nFails++; $display("[TB] FAIL halt_txn: got %0d grants, expected 0", obsQ.size()); end
  endtask

  task automatic test_reset_inflight();
    resetDut();
    loadReq(0, LEFT, 2'd1, 1'b0);
    loadReq(2, FORWARD, 2'd3, 1'b0);
    expQ.push_back({2'd0, LEFT, 2'd1});
    applyStimulus();
    tick(3);
    nChecks++;
    if ({busy, w_valid, req_ready[2]} !== 3'b100) begin
      nFails++; $display("[TB] FAIL rst_pre: got %b, expected 100", {busy, w_valid, req_ready[2]});
    end
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (req_ready !== 4'hF) begin nFails++; $display("[TB] FAIL rst_async_ready: got %h, expected f", req_ready); end
    nChecks++;
    if ({w_valid, w_ant_id, w_move, w_ph, busy, err} !== 9'd0) begin
      nFails++; $display("[TB] FAIL rst_async_out: got %b, expected 000000000", {w_valid, w_ant_id, w_move, w_ph, busy, err});
    end
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      nChecks++;
      if ({w_valid, busy, req_ready} !== 6'b001111) begin
        nFails++; $display("[TB] FAIL rst_slots_empty: cycle %0d got %b, expected 001111", i, {w_valid, busy, req_ready});
      end
    end
    while (expQ.size() > 0) begin
      txn_t e, o;
      e = expQ.pop_front();
      o = 'x;
      if (obsQ.size() > 0) o = obsQ.pop_front();
      nChecks++;
      if (o !== e) begin nFails++; $display("[TB] FAIL rst_txn: got %h, expected %h", o, e); end
    end
    nChecks++;
    if (obsQ.size() != 0) begin nFails++; $display("[TB] FAIL rst_extra: got %0d extra grants, expected 0", obsQ.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_escape();
    test_backpressure();
    test_timeout();
    test_timeout_edge();
    test_halt();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
